// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the LC-3b pipeline.
//
// Consumes the EX/MEM register outputs, performs the data-cache access for
// loads, stores, byte accesses and LDI/STI (pointer fetch followed by the real
// access), stalls the upstream pipeline until the access completes, and
// loads the MEM/WB register.
//
// Ports:
//   clk, reset_n              clock and synchronous active-low reset
//   in_valid                  EX/MEM holds a live instruction
//   mem_read/write/byte/indirect  decoded memory-operation controls
//   mem_address               effective address
//   mem_aluresult             ALU result, also the store data
//   mem_npc/ir/cs/drid        fields passed through to MEM/WB
//   dmem_*                    data-cache request/response handshake
//   mem_stall                 freezes the upstream pipeline registers
//   wb_*                      MEM/WB register outputs
module mem_stage #(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_byte,
    input  logic              mem_indirect,
    input  logic [WORD_W-1:0] mem_address,
    input  logic [WORD_W-1:0] mem_aluresult,
    input  logic [WORD_W-1:0] mem_npc,
    input  logic [WORD_W-1:0] mem_ir,
    input  logic [10:0]       mem_cs,
    input  logic [2:0]        mem_drid,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [WORD_W-1:0] dmem_address,
    output logic [WORD_W-1:0] dmem_wdata,
    output logic [1:0]        dmem_byte_enable,
    input  logic [WORD_W-1:0] dmem_rdata,
    input  logic              dmem_resp,
    output logic              mem_stall,
    output logic              wb_valid,
    output logic [WORD_W-1:0] wb_data,
    output logic [WORD_W-1:0] wb_npc,
    output logic [WORD_W-1:0] wb_ir,
    output logic [10:0]       wb_cs,
    output logic [2:0]        wb_drid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PTR  = 2'd1,
        ACC  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] ptr_q, ptr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [WORD_W-1:0] wb_data_q, wb_data_d;
    logic [WORD_W-1:0] wb_npc_q, wb_npc_d;
    logic [WORD_W-1:0] wb_ir_q, wb_ir_d;
    logic [10:0]       wb_cs_q, wb_cs_d;
    logic [2:0]        wb_drid_q, wb_drid_d;

    logic              mem_op;
    logic              is_store;
    logic [WORD_W-1:0] ea;
    logic [7:0]        rdata_byte;
    logic [WORD_W-1:0] byte_wdata;
    logic              load_wb;
    logic [WORD_W-1:0] load_value;

    assign mem_op   = mem_read | mem_write;
    // Read wins if the decoder ever sets both strobes.
    assign is_store = mem_write & ~mem_read;
    assign ea       = mem_indirect ? ptr_q : mem_address;

    // Byte stores replicate the low byte onto both lanes; the byte enable
    // selects the lane that is actually written.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_byte_lane
            assign byte_wdata[gi*8 +: 8] = mem_aluresult[7:0];
        end
    endgenerate

    assign rdata_byte = ea[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

    // Upstream advances on the same edge the final response arrives.
    assign mem_stall = in_valid & mem_op & ~((state_q == ACC) & dmem_resp);

    always_comb begin
        state_d          = state_q;
        ptr_d            = ptr_q;
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_address     = '0;
        dmem_wdata       = '0;
        dmem_byte_enable = 2'b00;
        load_wb          = 1'b0;
        load_value       = mem_aluresult;

        case (state_q)
            IDLE: begin
                // No request is issued here; a late response is ignored.
                if (in_valid) begin
                    if (mem_op) begin
                        state_d = mem_indirect ? PTR : ACC;
                    end else begin
                        load_wb = 1'b1;
                    end
                end
            end
            PTR: begin
                dmem_read        = 1'b1;
                dmem_address     = {mem_address[WORD_W-1:1], 1'b0};
                dmem_byte_enable = 2'b11;
                if (dmem_resp) begin
                    ptr_d   = dmem_rdata;
                    state_d = ACC;
                end
            end
            ACC: begin
                dmem_read  = mem_read;
                dmem_write = is_store;
                if (mem_byte) begin
                    dmem_address     = ea;
                    dmem_byte_enable = ea[0] ? 2'b10 : 2'b01;
                    dmem_wdata       = byte_wdata;
                end else begin
                    dmem_address     = {ea[WORD_W-1:1], 1'b0};
                    dmem_byte_enable = 2'b11;
                    dmem_wdata       = mem_aluresult;
                end
                if (dmem_resp) begin
                    load_wb = 1'b1;
                    state_d = IDLE;
                    if (mem_read) begin
                        load_value = mem_byte ? {8'h00, rdata_byte} : dmem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Any cycle that does not load MEM/WB injects a bubble.
        wb_valid_d = load_wb;
        wb_data_d  = load_wb ? load_value : wb_data_q;
        wb_npc_d   = load_wb ? mem_npc    : wb_npc_q;
        wb_ir_d    = load_wb ? mem_ir     : wb_ir_q;
        wb_cs_d    = load_wb ? mem_cs     : wb_cs_q;
        wb_drid_d  = load_wb ? mem_drid   : wb_drid_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_npc_q   <= '0;
            wb_ir_q    <= '0;
            wb_cs_q    <= '0;
            wb_drid_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_npc_q   <= wb_npc_d;
            wb_ir_q    <= wb_ir_d;
            wb_cs_q    <= wb_cs_d;
            wb_drid_q  <= wb_drid_d;
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_npc   = wb_npc_q;
    assign wb_ir    = wb_ir_q;
    assign wb_cs    = wb_cs_q;
    assign wb_drid  = wb_drid_q;

endmodule
